// File: rtl/demultiplexador_bo_if.sv
// Handshake bundle for the Bloco Operativo 1:4 demultiplexer.
// The source/consumer side uses master; the demux uses slave.
interface demultiplexador_bo_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   entrada;
    logic [1:0]         set;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   saida_a;
    logic [WIDTH-1:0]   saida_b;
    logic [WIDTH-1:0]   saida_c;
    logic [WIDTH-1:0]   saida_d;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [COUNT_W-1:0] cnt_a;
    logic [COUNT_W-1:0] cnt_b;
    logic [COUNT_W-1:0] cnt_c;
    logic [COUNT_W-1:0] cnt_d;

    modport master (
        output entrada, set, in_valid, out_ready,
        input  in_ready, out_valid,
        input  saida_a, saida_b, saida_c, saida_d,
        input  cnt_a, cnt_b, cnt_c, cnt_d
    );

    modport slave (
        input  entrada, set, in_valid, out_ready,
        output in_ready, out_valid,
        output saida_a, saida_b, saida_c, saida_d,
        output cnt_a, cnt_b, cnt_c, cnt_d
    );
endinterface

// File: rtl/demultiplexador_bo.sv
// Registered 1:4 demultiplexer with one-entry output slots,
// per-destination valid/ready handshake and delivered-word counters.
module demultiplexador_bo #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    demultiplexador_bo_if.slave bus
);
    logic [WIDTH-1:0]   dat_q [4];
    logic [COUNT_W-1:0] cnt_q [4];
    logic [3:0]         vld_q;
    logic [3:0]         sel;
    logic [3:0]         acc;
    logic [3:0]         drn;
    logic               rdy;

    always_comb begin
        sel = '0;
        unique case (bus.set)
            2'd0: sel = 4'b0001;
            2'd1: sel = 4'b0010;
            2'd2: sel = 4'b0100;
            2'd3: sel = 4'b1000;
        endcase
    end

    // Only the selected slot can stall the source; it frees up
    // in the same cycle its consumer takes the word.
    assign rdy = !rst && (!vld_q[bus.set] || bus.out_ready[bus.set]);
    assign acc = sel & {4{bus.in_valid && rdy}};
    assign drn = vld_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dat_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drn[i]) begin
                    cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
                end
                if (acc[i]) begin
                    dat_q[i] <= bus.entrada;
                    vld_q[i] <= 1'b1;
                end else if (drn[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld_q;
    assign bus.saida_a   = dat_q[0];
    assign bus.saida_b   = dat_q[1];
    assign bus.saida_c   = dat_q[2];
    assign bus.saida_d   = dat_q[3];
    assign bus.cnt_a     = cnt_q[0];
    assign bus.cnt_b     = cnt_q[1];
    assign bus.cnt_c     = cnt_q[2];
    assign bus.cnt_d     = cnt_q[3];
endmodule

// File: tb/tb_demultiplexador_bo.sv
// Bench for demultiplexador_bo: directed vector table, corner sequences
// and random traffic checked against a slot-level reference model.
module tb_demultiplexador_bo;
    logic clk;
    logic rst;

    demultiplexador_bo_if #(.WIDTH(16), .COUNT_W(8)) bus ();

    demultiplexador_bo #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: one word per destination plus a delivered tally.
    logic [15:0] md [4];
    bit          mv [4];
    logic [7:0]  mc [4];

    typedef struct {
        logic        r;
        logic        iv;
        logic [1:0]  s;
        logic [15:0] d;
        logic [3:0]  o;
        logic        erdy;
        logic [3:0]  eov;
        int          ci;
        logic [15:0] edat;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sa(input int i);
        case (i)
            0: return bus.saida_a;
            1: return bus.saida_b;
            2: return bus.saida_c;
            default: return bus.saida_d;
        endcase
    endfunction

    function automatic logic [7:0] ct(input int i);
        case (i)
            0: return bus.cnt_a;
            1: return bus.cnt_b;
            2: return bus.cnt_c;
            default: return bus.cnt_d;
        endcase
    endfunction

    function automatic logic [3:0] m_ov();
        return {mv[3], mv[2], mv[1], mv[0]};
    endfunction

    task automatic chk_model();
        chk("model out_valid", bus.out_valid, m_ov());
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model saida[%0d]", i), sa(i), md[i]);
            chk($sformatf("model cnt[%0d]", i), ct(i), mc[i]);
        end
    endtask

    // Apply one cycle of inputs, check in_ready before the edge,
    // advance the model with the edge and check registered state.
    task automatic cyc(input logic r, input logic iv, input logic [1:0] s,
                       input logic [15:0] d, input logic [3:0] o);
        bit exp_rdy;
        rst = r;
        bus.in_valid = iv;
        bus.set = s;
        bus.entrada = d;
        bus.out_ready = o;
        #1;
        exp_rdy = !r && (!mv[s] || o[s]);
        chk("model in_ready", bus.in_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 0; md[i] = '0; mc[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mv[i] && o[i]) begin
                    mv[i] = 0;
                    mc[i] = mc[i] + 8'd1;
                end
            end
            if (iv && exp_rdy) begin
                md[s] = d;
                mv[s] = 1;
            end
        end
        #1;
        chk_model();
    endtask

    logic [3:0]  snap_ov;
    logic [15:0] snap_sa [4];
    logic [7:0]  snap_ct [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; md[i] = 'x; mc[i] = 'x;
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.set = 2'd0;
        bus.entrada = '0;
        bus.out_ready = '0;
        @(negedge clk);

        //      r   iv  s  d         o        rdy eov      ci edat      ecnt
        vt[0] = '{1'b1, 1'b1, 2'd0, 16'h1234, 4'b0000, 1'b0, 4'b0000, 0, 16'h0000, 8'd0};
        vt[1] = '{1'b1, 1'b1, 2'd0, 16'h1234, 4'b0000, 1'b0, 4'b0000, 1, 16'h0000, 8'd0};
        vt[2] = '{1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0100, 2, 16'hBEEF, 8'd0};
        vt[3] = '{1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b0, 4'b0100, 2, 16'hBEEF, 8'd0};
        vt[4] = '{1'b0, 1'b1, 2'd0, 16'h0F0F, 4'b0000, 1'b1, 4'b0101, 0, 16'h0F0F, 8'd0};
        vt[5] = '{1'b0, 1'b1, 2'd1, 16'h1111, 4'b0000, 1'b1, 4'b0111, 1, 16'h1111, 8'd0};
        vt[6] = '{1'b0, 1'b1, 2'd1, 16'h2222, 4'b0010, 1'b1, 4'b0111, 1, 16'h2222, 8'd1};
        vt[7] = '{1'b0, 1'b0, 2'd0, 16'h5555, 4'b1111, 1'b1, 4'b0000, 2, 16'hBEEF, 8'd1};

        foreach (vt[k]) begin
            rst = vt[k].r;
            bus.in_valid = vt[k].iv;
            bus.set = vt[k].s;
            bus.entrada = vt[k].d;
            bus.out_ready = vt[k].o;
            #1;
            chk($sformatf("vec%0d in_ready", k), bus.in_ready, vt[k].erdy);
            cyc(vt[k].r, vt[k].iv, vt[k].s, vt[k].d, vt[k].o);
            chk($sformatf("vec%0d out_valid", k), bus.out_valid, vt[k].eov);
            chk($sformatf("vec%0d saida", k), sa(vt[k].ci), vt[k].edat);
            chk($sformatf("vec%0d cnt", k), ct(vt[k].ci), vt[k].ecnt);
        end

        // Counter wrap on D: 256 fill/drain pairs.
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'b0000);
        for (int k = 0; k < 256; k++) begin
            cyc(1'b0, 1'b1, 2'd3, 16'(k), 4'b0000);
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'b1000);
            if (k == 254) chk("cnt_d pre-wrap", bus.cnt_d, 8'hFF);
        end
        chk("cnt_d wrap", bus.cnt_d, 8'h00);
        chk("cnt_a after D", bus.cnt_a, 8'h00);
        chk("cnt_b after D", bus.cnt_b, 8'h00);
        chk("cnt_c after D", bus.cnt_c, 8'h00);
        chk("saida_d held", bus.saida_d, 16'h00FF);

        // All four full, then a one-cycle reset with traffic present.
        cyc(1'b0, 1'b1, 2'd0, 16'h000A, 4'b0000);
        cyc(1'b0, 1'b1, 2'd1, 16'h000B, 4'b0000);
        cyc(1'b0, 1'b1, 2'd2, 16'h000C, 4'b0000);
        cyc(1'b0, 1'b1, 2'd3, 16'h000D, 4'b0000);
        chk("all full", bus.out_valid, 4'b1111);
        chk("full blocks", bus.in_ready, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 16'h7777, 4'b1111);
        chk("rst out_valid", bus.out_valid, 4'b0000);
        chk("rst saida_a", bus.saida_a, 16'h0);
        chk("rst saida_b", bus.saida_b, 16'h0);
        chk("rst saida_c", bus.saida_c, 16'h0);
        chk("rst saida_d", bus.saida_d, 16'h0);
        chk("rst cnt_d", bus.cnt_d, 8'h0);

        // Idle input: set/entrada wander, nothing moves.
        cyc(1'b0, 1'b1, 2'd0, 16'hAAAA, 4'b0000);
        cyc(1'b0, 1'b1, 2'd2, 16'hCCCC, 4'b0000);
        snap_ov = bus.out_valid;
        for (int i = 0; i < 4; i++) begin
            snap_sa[i] = sa(i);
            snap_ct[i] = ct(i);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 4'b0000);
        end
        chk("idle out_valid", bus.out_valid, 4'b0101);
        chk("idle snap ov", bus.out_valid, snap_ov);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("idle saida[%0d]", i), sa(i), snap_sa[i]);
            chk($sformatf("idle cnt[%0d]", i), ct(i), snap_ct[i]);
        end
        chk("idle saida_c", bus.saida_c, 16'hCCCC);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                16'($urandom),
                4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
